cte_job_arbiter: RTL and testbench
==================================

// Module: cte_job_arbiter
// PURPOSE
//   Shares one CTE colour-transform engine between two job requesters.
//   Port 0 streams YUV 4:2:2 bytes (op_mode=0, YUV->RGB); port 1 streams RGB pixels (op_mode=1, RGB->YUV).
//   Grants are round-robin and change only at job boundaries.
//   The block drives op_mode/in_en, obeys CTE busy, counts CTE outputs to detect job completion, and reports done/error.
// PARAMETERS
//   LEN_W    10  width of job length fields (input beats per job)
//   TIMEOUT  64  max idle cycles without cte_out_valid in DRAIN before abort
// PORTS
//   clk            in   1      clock, all logic on rising edge
//   reset          in   1      synchronous, active-low (0 = reset)
//   req0           in   1      port-0 job request (level, held until ack0)
//   len0           in   LEN_W  port-0 input byte count, sampled at ack0
//   ack0           out  1      1-cycle pulse: port-0 job accepted
//   s0_valid       in   1      port-0 data beat valid
//   s0_data        in   8      port-0 YUV byte (U,Y,V,Y order)
//   s0_ready       out  1      port-0 beat accepted when valid&&ready
//   done0          out  1      1-cycle pulse: port-0 job complete
//   req1/len1/ack1 ...         same as port 0, for port 1
//   s1_valid       in   1      port-1 data beat valid
//   s1_data        in   24     port-1 RGB pixel
//   s1_ready       out  1      port-1 beat ready
//   done1          out  1      1-cycle pulse: port-1 job complete
//   err            out  1      1-cycle pulse: rejected length or drain timeout
//   cte_op_mode    out  1      to CTE op_mode
//   cte_in_en      out  1      to CTE in_en
//   cte_yuv_in     out  8      to CTE yuv_in
//   cte_rgb_in     out  24     to CTE rgb_in
//   cte_busy       in   1      from CTE busy
//   cte_out_valid  in   1      from CTE out_valid
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0, rr_last=1 (port 0 wins first tie).
//   FSM IDLE->GRANT->FEED->DRAIN->DONE->IDLE.
//   IDLE: a single request is granted. Both requesting: grant the port != rr_last.
//     - ackN pulses in this cycle; lenN and the port are latched; rr_last<=port.
//     - Length check:
//       - len==0: done pulse next cycle, no CTE activity.
//       - port 0 with len%4!=0, or port 1 with len odd: err pulse, job dropped, back to IDLE.
//   GRANT (1 cycle): cte_op_mode<=port; in_en held 0 so the mode settles before data.
//   FEED: sN_ready = !cte_busy (combinational, granted port only); cte_in_en = sN_valid && sN_ready.
//     - cte_yuv_in/cte_rgb_in carry sN_data while in_en=1, else 0.
//     - in_cnt++ per accepted beat; in_cnt==len -> DRAIN next cycle.
//   Expected output count: port 0 -> len/2 RGB pixels; port 1 -> 2*len YUV bytes.
//     - out_cnt++ on every cte_out_valid in FEED and DRAIN.
//   DRAIN: in_en=0, ready=0. out_cnt==expected -> DONE.
//     - TIMEOUT consecutive cycles without out_valid -> err pulse, IDLE, no done.
//   DONE: doneN pulses 1 cycle -> IDLE. A new grant is possible the following cycle.
//   cte_op_mode holds its value through DRAIN/DONE and IDLE; it changes only in GRANT.
//   Extra out_valid beyond expected (out_cnt saturates) is ignored.
//   Simultaneous out_valid and the final input beat: both counted in the same cycle.
//   reset=0 mid-job: immediate return to IDLE; the job is lost with no done/err.
//   Counters are LEN_W+1 bits, so 2*len cannot overflow.
// STRUCTURE
//   cte_pkg: FSM state enum, MODE_YUV2RGB=0/MODE_RGB2YUV=1, TIMEOUT default.
//   One sub-module, cte_rr_arbiter: 2-way round-robin with rr_last register.
//   The rest is the FSM, counters and muxing.
// TESTING
//   - Reset held low 2 cycles -> all outputs 0. First tie (req0=req1=1) -> ack0 first.
//   - Port-0 job len=8 with a CTE model (busy every other cycle) -> 8 in_en beats, never with busy=1.
//     - 4 out_valid -> done0 once, op_mode=0 throughout.
//   - Port-1 job len=2 -> 2 beats on cte_rgb_in, 4 out_valid -> done1, op_mode=1.
//   - Both requesting continuously, 3 jobs each -> grant order 0,1,0,1,0,1; no overlapping FEED.
//   - len0=6 -> err pulse, no ack-to-CTE traffic.
//     - Port-1 job where the model stops outputs -> err exactly TIMEOUT=64 cycles after the last out_valid.
//   - reset=0 asserted mid-FEED -> IDLE next cycle; a new job then completes normally.

Source files
------------

// File: rtl/cte_pkg.sv
// rtl/cte_pkg.sv - shared types and constants for the CTE job arbiter
package cte_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } cte_state_e;

    localparam logic MODE_YUV2RGB = 1'b0;
    localparam logic MODE_RGB2YUV = 1'b1;

    localparam int CTE_LEN_W   = 10;
    localparam int CTE_TIMEOUT = 64;

endpackage

// File: rtl/cte_rr_arbiter.sv
// rtl/cte_rr_arbiter.sv - two-way round-robin pick with a last-winner register
module cte_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic grant_valid,
    output logic grant_port
);

    logic rr_last;

    assign grant_valid = req0 | req1;
    // On a tie the port that did not win last time goes next.
    assign grant_port  = (req0 && req1) ? ~rr_last : req1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_last <= 1'b1;
        end else if (take) begin
            rr_last <= grant_port;
        end
    end

endmodule

// File: rtl/cte_job_arbiter.sv
// rtl/cte_job_arbiter.sv - shares one colour-transform engine between two job ports
module cte_job_arbiter
    import cte_pkg::*;
#(
    parameter int LEN_W   = CTE_LEN_W,
    parameter int TIMEOUT = CTE_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [LEN_W-1:0] len0,
    output logic             ack0,
    input  logic             s0_valid,
    input  logic [7:0]       s0_data,
    output logic             s0_ready,
    output logic             done0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len1,
    output logic             ack1,
    input  logic             s1_valid,
    input  logic [23:0]      s1_data,
    output logic             s1_ready,
    output logic             done1,
    output logic             err,
    output logic             cte_op_mode,
    output logic             cte_in_en,
    output logic [7:0]       cte_yuv_in,
    output logic [23:0]      cte_rgb_in,
    input  logic             cte_busy,
    input  logic             cte_out_valid
);

    localparam int CW = LEN_W + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    cte_state_e       state, state_next;
    logic             port_q;
    logic [LEN_W-1:0] len_q;
    logic [CW-1:0]    in_cnt, out_cnt, exp_cnt;
    logic [TW-1:0]    idle_cnt;

    logic             grant_valid, grant_port, take;
    logic [LEN_W-1:0] grant_len;
    logic             grant_bad, grant_zero;
    logic             ready_any, feed_valid, beat, in_last, out_full, timeout_hit;

    cte_rr_arbiter u_rr (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .take        (take),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign grant_len  = grant_port ? len1 : len0;
    assign grant_zero = (grant_len == '0);
    // YUV 4:2:2 needs whole U,Y,V,Y groups; RGB->YUV needs pixel pairs.
    assign grant_bad  = grant_port ? grant_len[0] : (grant_len[1:0] != 2'b00);

    assign exp_cnt     = port_q ? {len_q, 1'b0} : {2'b00, len_q[LEN_W-1:1]};
    assign out_full    = (out_cnt == exp_cnt);
    assign feed_valid  = port_q ? s1_valid : s0_valid;
    assign ready_any   = reset && (state == ST_FEED) && !cte_busy;
    assign beat        = ready_any && feed_valid;
    assign in_last     = ((in_cnt + CW'(1)) == {1'b0, len_q});
    assign timeout_hit = (idle_cnt == TW'(TIMEOUT - 1)) && !cte_out_valid;

    assign s0_ready   = ready_any && !port_q;
    assign s1_ready   = ready_any && port_q;
    assign cte_in_en  = beat;
    assign cte_yuv_in = (beat && !port_q) ? s0_data : 8'h00;
    assign cte_rgb_in = (beat && port_q) ? s1_data : 24'h000000;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        err        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    take = 1'b1;
                    ack0 = !grant_port;
                    ack1 = grant_port;
                    if (grant_bad) begin
                        err = 1'b1;
                    end else if (grant_zero) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_GRANT;
                    end
                end
            end
            ST_GRANT: state_next = ST_FEED;
            ST_FEED: begin
                if (beat && in_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_full) begin
                    state_next = ST_DONE;
                end else if (timeout_hit) begin
                    err        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                done0      = !port_q;
                done1      = port_q;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (!reset) begin
            state_next = ST_IDLE;
            take       = 1'b0;
            ack0       = 1'b0;
            ack1       = 1'b0;
            done0      = 1'b0;
            done1      = 1'b0;
            err        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            port_q      <= 1'b0;
            len_q       <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            idle_cnt    <= '0;
            cte_op_mode <= MODE_YUV2RGB;
        end else begin
            if (state == ST_IDLE && grant_valid) begin
                port_q  <= grant_port;
                len_q   <= grant_len;
                in_cnt  <= '0;
                out_cnt <= '0;
            end
            // Loaded on entry to GRANT so the engine sees a stable mode for a full cycle.
            if (state == ST_IDLE && state_next == ST_GRANT) begin
                cte_op_mode <= grant_port ? MODE_RGB2YUV : MODE_YUV2RGB;
            end
            if (beat) begin
                in_cnt <= in_cnt + CW'(1);
            end
            if ((state == ST_FEED || state == ST_DRAIN) && cte_out_valid && !out_full) begin
                out_cnt <= out_cnt + CW'(1);
            end
            if (state != ST_DRAIN || cte_out_valid) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cte_job_arbiter.sv
// tb/tb_cte_job_arbiter.sv - directed self-checking bench for cte_job_arbiter
module tb_cte_job_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [9:0]  len0, len1;
    logic        ack0, ack1;
    logic        s0_valid, s0_ready, done0;
    logic [7:0]  s0_data;
    logic        s1_valid, s1_ready, done1;
    logic [23:0] s1_data;
    logic        err;
    logic        cte_op_mode, cte_in_en;
    logic [7:0]  cte_yuv_in;
    logic [23:0] cte_rgb_in;
    logic        cte_busy, cte_out_valid;

    always #5 clk = ~clk;

    cte_job_arbiter #(.LEN_W(10), .TIMEOUT(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0          (req0),
        .len0          (len0),
        .ack0          (ack0),
        .s0_valid      (s0_valid),
        .s0_data       (s0_data),
        .s0_ready      (s0_ready),
        .done0         (done0),
        .req1          (req1),
        .len1          (len1),
        .ack1          (ack1),
        .s1_valid      (s1_valid),
        .s1_data       (s1_data),
        .s1_ready      (s1_ready),
        .done1         (done1),
        .err           (err),
        .cte_op_mode   (cte_op_mode),
        .cte_in_en     (cte_in_en),
        .cte_yuv_in    (cte_yuv_in),
        .cte_rgb_in    (cte_rgb_in),
        .cte_busy      (cte_busy),
        .cte_out_valid (cte_out_valid)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // requester and engine model state
    int   jobs_left0, jobs_left1, job_len0, job_len1;
    int   feed_left0, feed_left1, beat_idx0, beat_idx1, par0;
    int   pending, out_budget;
    logic busy_en, busy_phase, in_flight, cur_port;

    // per-test observations
    int st_ack0, st_ack1, st_done0, st_done1, st_err, st_inen, st_out;
    int st_busy_viol, st_mode_viol, st_data_viol, st_overlap, st_both_ready;
    int last_out_cyc, err_cyc;
    int grant_log[$];

    task automatic clear_stats();
        st_ack0 = 0; st_ack1 = 0; st_done0 = 0; st_done1 = 0; st_err = 0;
        st_inen = 0; st_out = 0; st_busy_viol = 0; st_mode_viol = 0;
        st_data_viol = 0; st_overlap = 0; st_both_ready = 0;
        last_out_cyc = -1; err_cyc = -1;
        grant_log.delete();
        pending = 0; par0 = 0; beat_idx0 = 0; beat_idx1 = 0;
        feed_left0 = 0; feed_left1 = 0; in_flight = 1'b0;
    endtask

    task automatic run_cycle();
        req0          = (jobs_left0 > 0);
        req1          = (jobs_left1 > 0);
        len0          = 10'(job_len0);
        len1          = 10'(job_len1);
        s0_valid      = (feed_left0 > 0);
        s0_data       = 8'(8'hA0 + beat_idx0);
        s1_valid      = (feed_left1 > 0);
        s1_data       = 24'(24'hC0FF00 + beat_idx1);
        cte_busy      = busy_en && busy_phase;
        cte_out_valid = (pending > 0) && (out_budget > 0);
        #1;
        if (ack0) begin
            st_ack0++; jobs_left0--; feed_left0 += job_len0; par0 = 0;
            grant_log.push_back(0);
            if (in_flight) st_overlap++;
            in_flight = 1'b1; cur_port = 1'b0;
        end
        if (ack1) begin
            st_ack1++; jobs_left1--; feed_left1 += job_len1;
            grant_log.push_back(1);
            if (in_flight) st_overlap++;
            in_flight = 1'b1; cur_port = 1'b1;
        end
        if (s0_ready && s1_ready) st_both_ready++;
        if (cte_in_en) begin
            st_inen++;
            if (cte_busy) st_busy_viol++;
            if (cte_op_mode !== cur_port) st_mode_viol++;
            if (s0_ready && s0_valid) begin
                if (cte_yuv_in !== s0_data || cte_rgb_in !== 24'h0) st_data_viol++;
                feed_left0--; beat_idx0++;
                if (par0 == 1) pending++;
                par0 = 1 - par0;
            end else if (s1_ready && s1_valid) begin
                if (cte_rgb_in !== s1_data || cte_yuv_in !== 8'h0) st_data_viol++;
                feed_left1--; beat_idx1++;
                pending += 2;
            end else begin
                st_data_viol++;
            end
        end
        if (cte_out_valid) begin
            pending--; out_budget--; st_out++; last_out_cyc = cyc;
        end
        if (done0) begin
            st_done0++; in_flight = 1'b0;
            if (cte_op_mode !== 1'b0) st_mode_viol++;
        end
        if (done1) begin
            st_done1++; in_flight = 1'b0;
            if (cte_op_mode !== 1'b1) st_mode_viol++;
        end
        if (err) begin
            st_err++; err_cyc = cyc; in_flight = 1'b0;
            feed_left0 = 0; feed_left1 = 0;
        end
        busy_phase = !busy_phase;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_idle(input int max_cyc, output bit timed_out);
        int n = 0;
        while ((jobs_left0 > 0 || jobs_left1 > 0 || in_flight) && n < max_cyc) begin
            run_cycle();
            n++;
        end
        timed_out = (jobs_left0 > 0 || jobs_left1 > 0 || in_flight);
    endtask

    task automatic test_reset();
        bit to;
        logic [73:0] outs;
        clear_stats();
        reset = 1'b0;
        jobs_left0 = 1; jobs_left1 = 1; job_len0 = 0; job_len1 = 0;
        run_cycle();
        run_cycle();
        outs = {ack0, ack1, done0, done1, err, s0_ready, s1_ready, cte_op_mode,
                cte_in_en, cte_yuv_in, cte_rgb_in, 32'h0};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        reset = 1'b1;
        run_cycle();
        n_cmp++;
        if (st_ack0 !== 1 || st_ack1 !== 0) begin
            n_fail++;
            $display("FAIL first_tie: ack0=%0d ack1=%0d expected 1/0", st_ack0, st_ack1);
        end
        run_until_idle(20, to);
        n_cmp++;
        if (to || st_done0 !== 1 || st_done1 !== 1 || st_ack1 !== 1) begin
            n_fail++;
            $display("FAIL zero_len_jobs: to=%0d done0=%0d done1=%0d ack1=%0d expected 0/1/1/1",
                     to, st_done0, st_done1, st_ack1);
        end
        n_cmp++;
        if (st_inen !== 0 || st_err !== 0) begin
            n_fail++;
            $display("FAIL zero_len_traffic: in_en=%0d err=%0d expected 0/0", st_inen, st_err);
        end
    endtask

    task automatic test_port0_job();
        bit to;
        clear_stats();
        busy_en = 1'b1; out_budget = 1000;
        jobs_left0 = 1; job_len0 = 8;
        run_until_idle(200, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL p0_timeout: job did not finish in 200 cycles"); end
        n_cmp++;
        if (st_inen !== 8) begin n_fail++; $display("FAIL p0_beats: got %0d expected 8", st_inen); end
        n_cmp++;
        if (st_busy_viol !== 0) begin n_fail++; $display("FAIL p0_busy: got %0d expected 0", st_busy_viol); end
        n_cmp++;
        if (st_out !== 4 || st_done0 !== 1) begin
            n_fail++;
            $display("FAIL p0_done: out=%0d done0=%0d expected 4/1", st_out, st_done0);
        end
        n_cmp++;
        if (st_mode_viol !== 0 || st_data_viol !== 0) begin
            n_fail++;
            $display("FAIL p0_mode_data: mode=%0d data=%0d expected 0/0", st_mode_viol, st_data_viol);
        end
    endtask

    task automatic test_port1_job();
        bit to;
        clear_stats();
        busy_en = 1'b0; out_budget = 1000;
        jobs_left1 = 1; job_len1 = 2;
        run_until_idle(100, to);
        n_cmp++;
        if (to || st_inen !== 2 || st_out !== 4 || st_done1 !== 1) begin
            n_fail++;
            $display("FAIL p1_job: to=%0d in_en=%0d out=%0d done1=%0d expected 0/2/4/1",
                     to, st_inen, st_out, st_done1);
        end
        n_cmp++;
        if (st_mode_viol !== 0 || st_data_viol !== 0 || st_done0 !== 0) begin
            n_fail++;
            $display("FAIL p1_mode_data: mode=%0d data=%0d done0=%0d expected 0/0/0",
                     st_mode_viol, st_data_viol, st_done0);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int exp_order[6] = '{0, 1, 0, 1, 0, 1};
        int got;
        clear_stats();
        busy_en = 1'b1; out_budget = 1000;
        jobs_left0 = 3; jobs_left1 = 3; job_len0 = 4; job_len1 = 2;
        run_until_idle(2000, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL rr_timeout: jobs did not finish"); end
        for (int i = 0; i < 6; i++) begin
            got = (i < grant_log.size()) ? grant_log[i] : -1;
            n_cmp++;
            if (got !== exp_order[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got, exp_order[i]);
            end
        end
        n_cmp++;
        if (st_overlap !== 0 || st_both_ready !== 0 || st_busy_viol !== 0) begin
            n_fail++;
            $display("FAIL rr_overlap: overlap=%0d both_ready=%0d busy=%0d expected 0/0/0",
                     st_overlap, st_both_ready, st_busy_viol);
        end
        n_cmp++;
        if (st_done0 !== 3 || st_done1 !== 3 || st_out !== 18 || st_mode_viol !== 0) begin
            n_fail++;
            $display("FAIL rr_done: done0=%0d done1=%0d out=%0d mode=%0d expected 3/3/18/0",
                     st_done0, st_done1, st_out, st_mode_viol);
        end
    endtask

    task automatic test_bad_len();
        bit to;
        clear_stats();
        busy_en = 1'b0; out_budget = 1000;
        jobs_left0 = 1; job_len0 = 6;
        run_until_idle(20, to);
        for (int i = 0; i < 4; i++) run_cycle();
        n_cmp++;
        if (st_err !== 1 || st_ack0 !== 1) begin
            n_fail++;
            $display("FAIL bad_len0: err=%0d ack0=%0d expected 1/1", st_err, st_ack0);
        end
        n_cmp++;
        if (st_inen !== 0 || st_done0 !== 0) begin
            n_fail++;
            $display("FAIL bad_len0_traffic: in_en=%0d done0=%0d expected 0/0", st_inen, st_done0);
        end
        jobs_left1 = 1; job_len1 = 3;
        run_until_idle(20, to);
        for (int i = 0; i < 4; i++) run_cycle();
        n_cmp++;
        if (st_err !== 2 || st_inen !== 0 || st_done1 !== 0) begin
            n_fail++;
            $display("FAIL bad_len1: err=%0d in_en=%0d done1=%0d expected 2/0/0",
                     st_err, st_inen, st_done1);
        end
    endtask

    task automatic test_timeout();
        bit to;
        clear_stats();
        busy_en = 1'b0; out_budget = 2;
        jobs_left1 = 1; job_len1 = 2;
        run_until_idle(200, to);
        n_cmp++;
        if (to || st_err !== 1 || st_done1 !== 0 || st_out !== 2) begin
            n_fail++;
            $display("FAIL timeout_abort: to=%0d err=%0d done1=%0d out=%0d expected 0/1/0/2",
                     to, st_err, st_done1, st_out);
        end
        n_cmp++;
        if (err_cyc - last_out_cyc !== 64) begin
            n_fail++;
            $display("FAIL timeout_gap: got %0d expected 64", err_cyc - last_out_cyc);
        end
    endtask

    task automatic test_reset_mid_feed();
        bit to;
        int n = 0;
        clear_stats();
        busy_en = 1'b0; out_budget = 1000;
        jobs_left0 = 1; job_len0 = 8;
        while (st_inen < 3 && n < 50) begin
            run_cycle();
            n++;
        end
        n_cmp++;
        if (st_inen !== 3) begin n_fail++; $display("FAIL midrst_feed: got %0d beats expected 3", st_inen); end
        reset = 1'b0;
        run_cycle();
        reset = 1'b1;
        feed_left0 = 0; in_flight = 1'b0; pending = 0;
        s0_valid = 1'b1;
        #1;
        n_cmp++;
        if (s0_ready !== 1'b0 || cte_in_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: ready=%0b in_en=%0b expected 0/0", s0_ready, cte_in_en);
        end
        jobs_left1 = 1; job_len1 = 2;
        run_until_idle(100, to);
        n_cmp++;
        if (to || st_done1 !== 1 || st_done0 !== 0 || st_err !== 0) begin
            n_fail++;
            $display("FAIL midrst_next_job: to=%0d done1=%0d done0=%0d err=%0d expected 0/1/0/0",
                     to, st_done1, st_done0, st_err);
        end
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
        s0_valid = 1'b0; s0_data = '0; s1_valid = 1'b0; s1_data = '0;
        cte_busy = 1'b0; cte_out_valid = 1'b0;
        jobs_left0 = 0; jobs_left1 = 0; job_len0 = 0; job_len1 = 0;
        busy_en = 1'b0; busy_phase = 1'b0; out_budget = 0; cur_port = 1'b0;
        test_reset();
        test_port0_job();
        test_port1_job();
        test_back_to_back();
        test_bad_len();
        test_timeout();
        test_reset_mid_feed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
